// File: rtl/cpu_pkg.sv
// Shared core definitions: word width, reset stack-pointer value and the stack
// operation decode used by stack_unit.
package cpu_pkg;

    localparam int WORD_W   = 16;
    localparam int RESET_SP = 0;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_FLUSH,
        OP_REPLACE,
        OP_PUSH,
        OP_PUSH_UNF,
        OP_PUSH_REJ,
        OP_POP,
        OP_POP_REJ
    } stack_op_e;

    // Priority decode of one cycle's requests against the current status.
    function automatic stack_op_e stack_decode(
        input logic push,
        input logic pop,
        input logic flush,
        input logic empty,
        input logic full
    );
        stack_op_e op;
        op = OP_IDLE;
        if (flush)
            op = OP_FLUSH;
        else if (push && pop)
            op = empty ? OP_PUSH_UNF : OP_REPLACE;
        else if (push)
            op = full ? OP_PUSH_REJ : OP_PUSH;
        else if (pop)
            op = empty ? OP_POP_REJ : OP_POP;
        return op;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack body storage: one synchronous write port, one asynchronous read port,
// no reset so it maps onto distributed memory.
module stack_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stack_unit.sv
// Bounded hardware stack with a registered top-of-stack, replace-top, flush and
// sticky overflow/underflow flags. Entries below the top live in stack_ram.
module stack_unit
    import cpu_pkg::*;
#(
    parameter  int DATA_W = WORD_W,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DATA_W-1:0] top_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [CNT_W-1:0]  count_reg, count_next;
    logic [DATA_W-1:0] top_reg, top_next;
    logic              ovf_reg, ovf_next;
    logic              unf_reg, unf_next;
    logic              ovf_set, unf_set;
    logic              ram_we;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              empty_int, full_int;
    stack_op_e         op;

    assign empty_int = (count_reg == '0);
    assign full_int  = (count_reg == CNT_W'(DEPTH));

    // The old top spills to entry count-1; the entry beneath it is count-2.
    // Out-of-range values at low counts are never used: writes and the pop
    // refill are both gated by the count.
    assign wr_addr = AW'(count_reg - CNT_W'(1));
    assign rd_addr = AW'(count_reg - CNT_W'(2));

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_addr),
        .wr_data (top_reg),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        op         = stack_decode(push, pop, flush, empty_int, full_int);
        count_next = count_reg;
        top_next   = top_reg;
        ram_we     = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        case (op)
            OP_FLUSH: begin
                count_next = '0;
                top_next   = '0;
            end
            OP_REPLACE: begin
                top_next = push_data;
            end
            OP_PUSH_UNF: begin
                count_next = CNT_W'(1);
                top_next   = push_data;
                unf_set    = 1'b1;
            end
            OP_PUSH: begin
                ram_we     = !empty_int;
                count_next = count_reg + CNT_W'(1);
                top_next   = push_data;
            end
            OP_PUSH_REJ: begin
                ovf_set = 1'b1;
            end
            OP_POP: begin
                count_next = count_reg - CNT_W'(1);
                top_next   = (count_reg > CNT_W'(1)) ? rd_data : '0;
            end
            OP_POP_REJ: begin
                unf_set = 1'b1;
            end
            default: begin
            end
        endcase
        // A new error outranks a simultaneous clear.
        ovf_next = ovf_set | (ovf_reg & ~clr_err);
        unf_next = unf_set | (unf_reg & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= CNT_W'(RESET_SP);
            top_reg   <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            top_reg   <= top_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    assign top_data  = top_reg;
    assign count     = count_reg;
    assign empty     = empty_int;
    assign full      = full_int;
    assign overflow  = ovf_reg;
    assign underflow = unf_reg;

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit (DEPTH = 4): directed vector table, async reset check,
// then randomized traffic against a queue-based stack model.
module tb_stack_unit;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push, pop, flush, clr_err;
    logic [DW-1:0] push_data;
    logic [DW-1:0] top_data;
    logic [CW-1:0] count;
    logic          empty, full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    stack_unit #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .flush     (flush),
        .clr_err   (clr_err),
        .top_data  (top_data),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          push;
        logic          pop;
        logic          flush;
        logic          clr;
        logic [DW-1:0] d;
        int            c;
        logic [DW-1:0] t;
        logic          ov;
        logic          un;
    } vec_t;

    vec_t vecs[$];

    // Reference model: stack as a queue, top at the back.
    logic [DW-1:0] mq[$];
    logic          m_ovf, m_unf;

    function automatic vec_t mk(input logic p, input logic o, input logic f, input logic c,
                                input logic [DW-1:0] d, input int ec, input logic [DW-1:0] et,
                                input logic eov, input logic eun);
        vec_t v;
        v.push = p; v.pop = o; v.flush = f; v.clr = c; v.d = d;
        v.c = ec; v.t = et; v.ov = eov; v.un = eun;
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int ec, input logic [DW-1:0] et,
                               input logic eov, input logic eun);
        cmp({tag, " count"}, int'(count), ec);
        cmp({tag, " top_data"}, int'(top_data), int'(et));
        cmp({tag, " empty"}, int'(empty), int'(ec == 0));
        cmp({tag, " full"}, int'(full), int'(ec == DEPTH));
        cmp({tag, " overflow"}, int'(overflow), int'(eov));
        cmp({tag, " underflow"}, int'(underflow), int'(eun));
    endtask

    task automatic drive(input logic p, input logic o, input logic f, input logic c,
                         input logic [DW-1:0] d);
        push = p; pop = o; flush = f; clr_err = c; push_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic p, input logic o, input logic f, input logic c,
                              input logic [DW-1:0] d);
        logic so, su;
        so = 1'b0;
        su = 1'b0;
        if (f)
            mq.delete();
        else if (p && o && mq.size() > 0)
            mq[mq.size()-1] = d;
        else if (p && o) begin
            mq.push_back(d);
            su = 1'b1;
        end else if (p && mq.size() < DEPTH)
            mq.push_back(d);
        else if (p)
            so = 1'b1;
        else if (o && mq.size() > 0)
            void'(mq.pop_back());
        else if (o)
            su = 1'b1;
        m_ovf = so ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = su ? 1'b1 : (c ? 1'b0 : m_unf);
    endtask

    function automatic logic [DW-1:0] model_top();
        return (mq.size() == 0) ? '0 : mq[mq.size()-1];
    endfunction

    // Async reset asserted and released mid-cycle; outputs must clear at once.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("%s: async reset asserted between edges", tag);
        check_state(tag, 0, '0, 1'b0, 1'b0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, '0);
        rst_n = 1'b0;
        #12;
        check_state("reset", 0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic LIFO order
        vecs.push_back(mk(1,0,0,0,16'h5, 1,16'h5,0,0));
        vecs.push_back(mk(1,0,0,0,16'h4, 2,16'h4,0,0));
        vecs.push_back(mk(1,0,0,0,16'h2, 3,16'h2,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 2,16'h4,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h5,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 0,16'h0,0,0));
        // Fill to DEPTH, then overflow
        vecs.push_back(mk(1,0,0,0,16'h1, 1,16'h1,0,0));
        vecs.push_back(mk(1,0,0,0,16'h2, 2,16'h2,0,0));
        vecs.push_back(mk(1,0,0,0,16'h3, 3,16'h3,0,0));
        vecs.push_back(mk(1,0,0,0,16'h4, 4,16'h4,0,0));
        vecs.push_back(mk(1,0,0,0,16'h5, 4,16'h4,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0, 4,16'h4,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 3,16'h3,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 2,16'h2,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h1,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 0,16'h0,0,0));
        // Underflow, clear, set-wins
        vecs.push_back(mk(0,1,0,0,16'h0, 0,16'h0,0,1));
        vecs.push_back(mk(0,0,0,1,16'h0, 0,16'h0,0,0));
        vecs.push_back(mk(0,1,0,1,16'h0, 0,16'h0,0,1));
        vecs.push_back(mk(0,0,0,1,16'h0, 0,16'h0,0,0));
        // Replace-top, mid and full
        vecs.push_back(mk(1,0,0,0,16'h3, 1,16'h3,0,0));
        vecs.push_back(mk(1,0,0,0,16'h7, 2,16'h7,0,0));
        vecs.push_back(mk(1,1,0,0,16'h9, 2,16'h9,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 1,16'h3,0,0));
        vecs.push_back(mk(1,0,0,0,16'h7, 2,16'h7,0,0));
        vecs.push_back(mk(1,0,0,0,16'h8, 3,16'h8,0,0));
        vecs.push_back(mk(1,0,0,0,16'h6, 4,16'h6,0,0));
        vecs.push_back(mk(1,1,0,0,16'h9, 4,16'h9,0,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 3,16'h8,0,0));
        // Flush with push; error flags held, clr_err still honoured
        vecs.push_back(mk(1,0,0,0,16'h1, 4,16'h1,0,0));
        vecs.push_back(mk(1,0,0,0,16'h2, 4,16'h1,1,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 3,16'h8,1,0));
        vecs.push_back(mk(1,0,1,0,16'h5, 0,16'h0,1,0));
        vecs.push_back(mk(0,1,0,0,16'h0, 0,16'h0,1,1));
        vecs.push_back(mk(0,0,1,0,16'h0, 0,16'h0,1,1));
        vecs.push_back(mk(0,0,1,1,16'h0, 0,16'h0,0,0));
        // Push+pop on empty: push executes, underflow set
        vecs.push_back(mk(1,1,0,0,16'h55, 1,16'h55,0,1));
        vecs.push_back(mk(0,1,0,1,16'h0, 0,16'h0,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].clr, vecs[i].d);
            step();
            $display("vec %0d: push=%0b pop=%0b flush=%0b clr=%0b d=%h -> count=%0d top=%h ovf=%0b unf=%0b",
                     i, vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].clr, vecs[i].d,
                     count, top_data, overflow, underflow);
            check_state($sformatf("vec%0d", i), vecs[i].c, vecs[i].t, vecs[i].ov, vecs[i].un);
        end

        // Mid-sequence async reset discards entries and flags
        drive(1, 0, 0, 0, 16'hAA); step();
        drive(1, 0, 0, 0, 16'hBB); step();
        drive(1, 0, 0, 0, 16'hCC); step();
        drive(1, 0, 0, 0, 16'hDD); step();
        drive(1, 0, 0, 0, 16'hEE); step();
        drive(0, 1, 0, 0, 16'h0);  step();
        $display("pre-reset: count=%0d top=%h ovf=%0b", count, top_data, overflow);
        check_state("pre-reset", 3, 16'hCC, 1'b1, 1'b0);
        async_reset("mid-reset");
        drive(1, 0, 0, 0, 16'h31); step();
        $display("post-reset push: count=%0d top=%h", count, top_data);
        check_state("post-reset", 1, 16'h31, 1'b0, 1'b0);
        async_reset("rnd-start");

        for (int n = 0; n < 600; n++) begin
            logic p, o, f, c;
            logic [DW-1:0] d;
            p = ($urandom_range(0, 99) < 50);
            o = ($urandom_range(0, 99) < 40);
            f = ($urandom_range(0, 99) < 3);
            c = ($urandom_range(0, 99) < 10);
            d = DW'($urandom);
            drive(p, o, f, c, d);
            model_step(p, o, f, c, d);
            step();
            $display("rnd %0d: push=%0b pop=%0b flush=%0b clr=%0b d=%h -> count=%0d top=%h ovf=%0b unf=%0b",
                     n, p, o, f, c, d, count, top_data, overflow, underflow);
            check_state($sformatf("rnd%0d", n), mq.size(), model_top(), m_ovf, m_unf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
